reorder_buffer: RTL

- Circular in-order reorder buffer that sits directly downstream of the reservation station.
- Allocates one entry per issued instruction and returns the entry's ROB id to the issue stage.
- Captures ALU results from the reservation-station write-back port.
- Retires completed entries strictly in program order onto the commit CDB, which feeds back into the reservation station and register file. Also answers two combinational operand-readiness queries for the issue stage.

---
 rtl/reorder_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, captures write-backs,
// retires from head onto a registered commit CDB, answers two operand queries.
module reorder_buffer #(
    parameter int ROB_CAP       = 8,
    parameter int ROB_INDEX_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     issue_req,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_done,
    input  logic [31:0]              issue_val,
    output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    output logic                     full,
    output logic                     empty,
    input  logic                     rs_ready,
    input  logic [ROB_INDEX_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_result,
    input  logic [ROB_INDEX_BIT-1:0] qry1_id,
    input  logic [ROB_INDEX_BIT-1:0] qry2_id,
    output logic                     qry1_ready,
    output logic                     qry2_ready,
    output logic [31:0]              qry1_val,
    output logic [31:0]              qry2_val,
    output logic                     cdb_req,
    output logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
    output logic [4:0]               cdb_rd,
    output logic [31:0]              cdb_val
);

    logic [ROB_CAP-1:0]         busy_q, rdy_q;
    logic [ROB_CAP-1:0][4:0]    rd_q;
    logic [ROB_CAP-1:0][31:0]   val_q;
    logic [ROB_INDEX_BIT-1:0]   head, tail;
    logic [ROB_INDEX_BIT:0]     count;
    logic                       do_issue, do_commit, do_wb, advance;

    assign full         = (count == (ROB_INDEX_BIT+1)'(ROB_CAP));
    assign empty        = (count == '0);
    assign issue_rob_id = tail;

    assign do_issue  = issue_req && !full;
    assign do_commit = busy_q[head] && rdy_q[head];
    assign do_wb     = rs_ready && busy_q[rs_rob_id];
    assign advance   = rst_in && !clear && rdy_in;

    // Query bypasses a same-cycle write-back so issue need not wait an edge.
    function automatic logic [32:0] lookup(input logic [ROB_INDEX_BIT-1:0] id);
        logic hit;
        hit = rs_ready && (rs_rob_id == id);
        if (!busy_q[id])
            return '0;
        else if (hit)
            return {1'b1, rs_result};
        else
            return {rdy_q[id], val_q[id]};
    endfunction

    assign {qry1_ready, qry1_val} = lookup(qry1_id);
    assign {qry2_ready, qry2_val} = lookup(qry2_id);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q     <= '0;
            rdy_q      <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cdb_req    <= 1'b0;
            cdb_rob_id <= '0;
            cdb_rd     <= '0;
            cdb_val    <= '0;
        end else if (clear) begin
            busy_q     <= '0;
            rdy_q      <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cdb_req    <= 1'b0;
            cdb_rob_id <= '0;
            cdb_rd     <= '0;
            cdb_val    <= '0;
        end else if (rdy_in) begin
            if (do_wb)
                rdy_q[rs_rob_id] <= 1'b1;
            if (do_issue) begin
                busy_q[tail] <= 1'b1;
                rdy_q[tail]  <= issue_done;
                tail         <= tail + 1'b1;
            end
            cdb_req <= do_commit;
            if (do_commit) begin
                busy_q[head] <= 1'b0;
                head         <= head + 1'b1;
                cdb_rob_id   <= head;
                cdb_rd       <= rd_q[head];
                cdb_val      <= val_q[head];
            end
            case ({do_issue, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through busy/ready.
    always_ff @(posedge clk_in) begin
        if (advance) begin
            if (do_wb)
                val_q[rs_rob_id] <= rs_result;
            if (do_issue) begin
                rd_q[tail]  <= issue_rd;
                val_q[tail] <= issue_val;
            end
        end
    end

endmodule
